// File: rtl/motor_pwm_gen.sv
// Multi-channel PWM generator with frame-synchronous duty updates.
// Duty writes land in shadow registers and are copied to active duties at frame boundaries.
module motor_pwm_gen #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8,
  parameter int PERIOD    = 200,
  parameter int CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tick_clk,
  input  logic                 arm,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CH_WIDTH-1:0]  wr_ch,
  input  logic [CNT_WIDTH-1:0] wr_duty,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 frame_start,
  output logic                 running
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] PMAX = CNT_WIDTH'(PERIOD);

  typedef enum logic [1:0] {
    DISARMED,
    RUN,
    STOPPING
  } state_t;

  state_t state, state_n;

  logic [CNT_WIDTH-1:0] count, count_n;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] shadow;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] active;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] active_n;
  logic [NUM_CH-1:0] pwm_n;
  logic [CNT_WIDTH-1:0] duty_c;
  logic tick_q, tick, wrap, boundary;
  logic fs_n, load;

  assign tick     = tick_clk & ~tick_q;
  assign wrap     = tick & (count == LAST);
  assign boundary = wrap & (state != DISARMED);
  assign wr_ready = ~boundary;
  assign running  = (state != DISARMED);
  assign duty_c   = (wr_duty > PMAX) ? PMAX : wr_duty;

  always_comb begin
    state_n  = state;
    count_n  = count;
    active_n = active;
    fs_n     = 1'b0;
    load     = 1'b0;
    if (tick && state != DISARMED)
      count_n = wrap ? '0 : count + CNT_WIDTH'(1);
    unique case (state)
      DISARMED: begin
        count_n = '0;
        load    = 1'b1;
        if (tick && arm) begin
          state_n = RUN;
          fs_n    = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          load = 1'b1;
          fs_n = 1'b1;
        end
        if (!arm) state_n = STOPPING;
      end
      STOPPING: begin
        // Re-arming on the last tick simply continues into a new frame.
        if (arm) begin
          state_n = RUN;
          if (wrap) begin
            load = 1'b1;
            fs_n = 1'b1;
          end
        end else if (wrap) begin
          state_n = DISARMED;
        end
      end
      default: state_n = DISARMED;
    endcase
    if (load) active_n = shadow;
    for (int c = 0; c < NUM_CH; c++)
      pwm_n[c] = (state_n != DISARMED) &&
                 (count_n < active_n[c]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= DISARMED;
      count       <= '0;
      shadow      <= '0;
      active      <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      tick_q      <= 1'b1;
    end else begin
      state       <= state_n;
      count       <= count_n;
      active      <= active_n;
      pwm_out     <= pwm_n;
      frame_start <= fs_n;
      tick_q      <= tick_clk;
      for (int c = 0; c < NUM_CH; c++)
        if (wr_valid && wr_ready &&
            wr_ch == CH_WIDTH'(c))
          shadow[c] <= duty_c;
    end
  end

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Self-checking bench for motor_pwm_gen.
// A cycle model feeds an expected-output queue that each scenario drains.
module tb_motor_pwm_gen;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick_clk = 1'b1;
  logic       arm = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_ch = '0;
  logic [7:0] wr_duty = '0;
  logic       wr_ready;
  logic [3:0] pwm_out;
  logic       frame_start;
  logic       running;

  int checks = 0;
  int failures = 0;
  bit tick_en = 1'b0;

  logic [6:0] exp_q[$];
  logic [6:0] e, got;

  int m_state, m_cnt;
  bit m_tq, m_fs;
  int m_sh[4];
  int m_act[4];
  logic [3:0] m_pwm;

  motor_pwm_gen #(
    .NUM_CH(4), .CNT_WIDTH(8),
    .PERIOD(P), .CH_WIDTH(3)
  ) dut (
    .clk(clk), .resetn(resetn),
    .tick_clk(tick_clk), .arm(arm),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_out(pwm_out),
    .frame_start(frame_start),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_cnt = 0;
    m_tq = 1'b1; m_fs = 1'b0;
    m_pwm = '0;
    for (int c = 0; c < 4; c++) begin
      m_sh[c] = 0; m_act[c] = 0;
    end
  endtask

  // One clk: model the edge, then toggle tick_clk (divide-by-2) and queue the expectation.
  task automatic adv();
    bit tk, bnd, acc, rdy;
    int nsh[4];
    @(posedge clk);
    tk  = tick_clk && !m_tq;
    bnd = tk && m_cnt == P-1 && m_state != 0;
    acc = wr_valid && !bnd;
    nsh = m_sh;
    if (acc && wr_ch < 4)
      nsh[wr_ch] = (wr_duty > P) ? P : int'(wr_duty);
    m_fs = 1'b0;
    if (m_state == 0) begin
      m_act = m_sh;
      if (tk && arm) begin m_state = 1; m_fs = 1'b1; end
    end else if (tk && m_cnt == P-1) begin
      m_cnt = 0;
      if (m_state == 2 && !arm) m_state = 0;
      else begin
        m_act = m_sh; m_fs = 1'b1;
        m_state = arm ? 1 : 2;
      end
    end else begin
      if (tk) m_cnt++;
      m_state = arm ? 1 : 2;
    end
    m_sh = nsh;
    m_tq = tick_clk;
    for (int c = 0; c < 4; c++)
      m_pwm[c] = (m_state != 0) && (m_cnt < m_act[c]);
    @(negedge clk);
    if (tick_en) tick_clk = ~tick_clk;
    #1;
    rdy = !(tick_clk && !m_tq && m_cnt == P-1 && m_state != 0);
    exp_q.push_back({m_pwm, m_fs, m_state != 0, rdy});
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    got = {pwm_out, frame_start, running, wr_ready};
    checks++;
    if (got !== 7'b0000001) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0000001", got);
    end
    @(negedge clk); #1;
    resetn = 1'b1;
    arm = 1'b1;
    // tick_clk held high through release must not start a frame
    for (int i = 0; i < 4; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_hold got=%b exp=%b", got, e);
      end
    end
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_tick running=%b exp=0", running);
    end
    arm = 1'b0;
    tick_en = 1'b1;
  endtask

  task automatic test_basic();
    int duties[4] = '{3, 0, 10, 15};
    int hi0, hi1, hi23, fsn;
    bit found;
    for (int c = 0; c < 4; c++) begin
      wr_valid = 1'b1; wr_ch = 3'(c);
      wr_duty = 8'(duties[c]);
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL basic_wr got=%b exp=%b", got, e);
      end
    end
    wr_valid = 1'b0;
    arm = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL basic_arm got=%b exp=%b", got, e);
      end
      found = frame_start;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL basic_first_frame frame_start=0 exp=1");
    end
    hi0 = 0; hi1 = 0; hi23 = 0; fsn = 0;
    for (int i = 0; i < 40; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL basic_run got=%b exp=%b", got, e);
      end
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      hi23 += int'(pwm_out[3:2] == 2'b11);
      fsn += int'(frame_start);
    end
    checks++;
    if (hi0 != 12 || hi1 != 0 || hi23 != 40 || fsn != 2) begin
      failures++;
      $display("FAIL basic_counts hi0=%0d hi1=%0d hi23=%0d fs=%0d exp 12 0 40 2",
               hi0, hi1, hi23, fsn);
    end
  endtask

  task automatic test_shadow();
    int hi;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL shadow_seek got=%b exp=%b", got, e);
      end
      found = (m_cnt == 4);
    end
    wr_valid = 1'b1; wr_ch = 3'd0; wr_duty = 8'd7;
    checks++;
    if (wr_ready !== 1'b1 || pwm_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL shadow_mid ready=%b pwm0=%b exp 1 0",
               wr_ready, pwm_out[0]);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      adv();
      wr_valid = 1'b0;
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL shadow_wait got=%b exp=%b", got, e);
      end
      found = frame_start;
    end
    hi = int'(pwm_out[0]);
    for (int i = 1; i < 20; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL shadow_frame got=%b exp=%b", got, e);
      end
      hi += int'(pwm_out[0]);
    end
    checks++;
    if (!found || hi != 14) begin
      failures++;
      $display("FAIL shadow_width high=%0d exp=14", hi);
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL bp_seek got=%b exp=%b", got, e);
      end
      found = !e[0];
    end
    wr_valid = 1'b1; wr_ch = 3'd0; wr_duty = 8'd2;
    checks++;
    if (!found || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_low wr_ready=%b exp=0", wr_ready);
    end
    adv();
    e = exp_q.pop_front();
    got = {pwm_out, frame_start, running, wr_ready};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL bp_boundary got=%b exp=%b", got, e);
    end
    hi = int'(pwm_out[0]);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_high wr_ready=%b exp=1", wr_ready);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      adv();
      wr_valid = 1'b0;
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL bp_frame got=%b exp=%b", got, e);
      end
      found = frame_start;
      if (!found) hi += int'(pwm_out[0]);
    end
    checks++;
    if (hi != 14) begin
      failures++;
      $display("FAIL bp_old_width high=%0d exp=14", hi);
    end
    hi = int'(pwm_out[0]);
    for (int i = 1; i < 20; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL bp_next got=%b exp=%b", got, e);
      end
      hi += int'(pwm_out[0]);
    end
    checks++;
    if (hi != 4) begin
      failures++;
      $display("FAIL bp_new_width high=%0d exp=4", hi);
    end
  endtask

  task automatic test_disarm();
    int fsn, idle;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL disarm_seek got=%b exp=%b", got, e);
      end
      found = (m_cnt == 2 && m_state == 1);
    end
    arm = 1'b0;
    fsn = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL disarm_stop got=%b exp=%b", got, e);
      end
      fsn += int'(frame_start);
      found = !running;
    end
    checks++;
    if (!found || fsn != 0 || pwm_out !== 4'b0) begin
      failures++;
      $display("FAIL disarm_end stopped=%b fs=%0d pwm=%b exp 1 0 0000",
               found, fsn, pwm_out);
    end
    arm = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rearm_seek got=%b exp=%b", got, e);
      end
      if (m_cnt == 2 && m_state == 1) arm = 1'b0;
      found = (m_cnt == 5 && !arm);
    end
    arm = 1'b1;
    fsn = 0; idle = 0;
    for (int i = 0; i < 40; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rearm_run got=%b exp=%b", got, e);
      end
      fsn += int'(frame_start);
      idle += int'(!running);
    end
    checks++;
    if (!found || fsn != 2 || idle != 0) begin
      failures++;
      $display("FAIL rearm_cont fs=%0d idle=%0d exp 2 0", fsn, idle);
    end
  endtask

  task automatic test_reset_mid();
    int hi, run_n;
    bit found, r;
    for (int c = 0; c < 4; c++) begin
      wr_valid = 1'b1; wr_ch = 3'(c); wr_duty = 8'd10;
      for (int k = 0; k < 3; k++) begin
        r = wr_ready;
        adv();
        e = exp_q.pop_front();
        got = {pwm_out, frame_start, running, wr_ready};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL rst_wr got=%b exp=%b", got, e);
        end
        if (r) break;
      end
    end
    wr_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rst_seek got=%b exp=%b", got, e);
      end
      found = (m_cnt == 6 && m_pwm == 4'b1111);
    end
    checks++;
    if (!found || pwm_out !== 4'b1111) begin
      failures++;
      $display("FAIL rst_pre pwm=%b exp=1111", pwm_out);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 4'b0 || running !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL rst_async pwm=%b run=%b fs=%b exp 0000 0 0",
               pwm_out, running, frame_start);
    end
    model_reset();
    @(negedge clk); #1;
    resetn = 1'b1;
    hi = 0; run_n = 0;
    for (int i = 0; i < 40; i++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rst_after got=%b exp=%b", got, e);
      end
      hi += int'(pwm_out != 4'b0);
      run_n += int'(running);
    end
    checks++;
    if (hi != 0 || run_n == 0) begin
      failures++;
      $display("FAIL rst_duties_lost high=%0d running=%0d exp 0 >0", hi, run_n);
    end
  endtask

  task automatic test_invalid_ch();
    int hi;
    wr_valid = 1'b1; wr_ch = 3'd4; wr_duty = 8'd5;
    for (int k = 0; k < 3 && !wr_ready; k++) begin
      adv();
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL inv_seek got=%b exp=%b", got, e);
      end
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL inv_ready wr_ready=%b exp=1", wr_ready);
    end
    hi = 0;
    for (int i = 0; i < 44; i++) begin
      adv();
      if (i == 0) wr_ch = 3'd7;
      if (i == 2) wr_valid = 1'b0;
      e = exp_q.pop_front();
      got = {pwm_out, frame_start, running, wr_ready};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL inv_run got=%b exp=%b", got, e);
      end
      hi += int'(pwm_out != 4'b0);
    end
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL inv_no_change high=%0d exp=0", hi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_back_to_back();
    test_disarm();
    test_reset_mid();
    test_invalid_ch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
